dh_encrypt_seq: RTL and testbench
=================================

DH_ENCRYPT_SEQ -- requirements
Module: dh_encrypt_seq

Interface
REQ-001 SHALL have parameter: DATA_W, 32, width of modulus p and exponent x (also of the internal accumulator and base registers).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a round; sampled only in IDLE.
REQ-005 SHALL have port: r1  input  4  plaintext nibble to encrypt.
REQ-006 SHALL have port: r2  input  4  public base, and the reference value for the replay check.
REQ-007 SHALL have port: c1  input  4  received cipher nibble.
REQ-008 SHALL have port: p  input  DATA_W  modulus.
REQ-009 SHALL have port: x  input  DATA_W  private exponent.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: err  output  1  last round aborted because p==0.
REQ-013 SHALL have port: true  output  1  last round produced a new cipher.
REQ-014 SHALL have port: c2  output  4  output cipher nibble.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SQ, MUL, CHECK.
REQ-016 SHALL accept start in IDLE (the accepting edge) and latch r1, r2, c1, p, x; inputs SHALL be don't-care afterwards until done.
REQ-017 SHALL ignore start while busy; no queuing.
REQ-018 LOAD: if p==0 SHALL set err=1, c2=0, true=0, pulse done and go to IDLE; else acc=1, base=r2 mod p, bit index i=DATA_W-1, go to SQ.
REQ-019 SQ: acc=(acc*acc) mod p, using a 2*DATA_W-bit product; next state MUL if x[i]==1.
REQ-020 SQ: if x[i]==0, SHALL go to SQ with i-1, or to CHECK when i==0.
REQ-021 MUL: acc=(acc*base) mod p; next state SQ with i-1, or CHECK when i==0.
REQ-022 CHECK: k=acc[3:0]; if (k XOR c1)==r2, SHALL set c2=0, true=0; else c2=k XOR r1, true=1.
REQ-023 CHECK: SHALL set err=0, pulse done, and go to IDLE.
REQ-024 Latency: done SHALL be set by edge N after the accepting edge, N=2+DATA_W+popcount(x); for DATA_W=32, N=34+popcount(x). For p==0, N=1.
REQ-025 done SHALL be high for exactly one cycle; busy SHALL be low in the cycle done is high.
REQ-026 c2, true, err SHALL hold their values until the next completion or reset.
REQ-027 SHALL accept a new start in the cycle done is high, since the FSM is then in IDLE.
REQ-028 Boundaries: x==0 SHALL give acc=1; p==1 SHALL give acc=0; r2>=p SHALL be reduced in LOAD.

Reset
REQ-029 When rst==0 at a rising edge, SHALL set state=IDLE and busy=done=err=true=0, c2=0, and clear acc, base and i.
REQ-030 Reset mid-round SHALL abandon the round without a done pulse; start SHALL be accepted from the first edge with rst==1.

Verification
REQ-031 r2=3, x=5, p=7, c1=6, r1=x -> k=5, done at edge 36, c2=0, true=0, err=0.
REQ-032 r2=2, x=10, p=13, c1=0, r1=5 -> k=10, done at edge 36, c2=0xF, true=1.
REQ-033 x=0, r2=9, p=11, c1=1, r1=3 -> k=1, done at edge 34, c2=2, true=1.
REQ-034 p=0 -> done and err=1 at edge 1, c2=0, true=0; next round with valid p clears err.
REQ-035 start pulsed at edges 5 and 20 of a round -> ignored, single done, result unchanged; start in the done cycle -> accepted.
REQ-036 rst low at edge 10 of a round -> next cycle all outputs 0, state IDLE, no done; a restarted round completes correctly.

Source files
------------

// File: rtl/dh_encrypt_seq.sv
// dh_encrypt_seq
//   Sequential Diffie-Hellman style nibble cipher. One round computes
//   acc = r2^x mod p by MSB-first square-and-multiply, takes k = acc[3:0]
//   as the key nibble and either encrypts r1 (c2 = k ^ r1, true = 1) or,
//   when the received cipher c1 decrypts back to the reference r2, reports
//   a replay (c2 = 0, true = 0). A zero modulus aborts the round with err.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-low reset
//   start  in   round request, sampled only while idle
//   r1     in   [3:0]        plaintext nibble
//   r2     in   [3:0]        public base / replay reference
//   c1     in   [3:0]        received cipher nibble
//   p      in   [DATA_W-1:0] modulus
//   x      in   [DATA_W-1:0] private exponent
//   busy   out  high whenever a round is in progress
//   done   out  one-cycle completion pulse
//   err    out  last round aborted because p was zero
//   true   out  last round produced a new cipher
//   c2     out  [3:0]        output cipher nibble
module dh_encrypt_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        r1,
    input  logic [3:0]        r2,
    input  logic [3:0]        c1,
    input  logic [DATA_W-1:0] p,
    input  logic [DATA_W-1:0] x,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              true,
    output logic [3:0]        c2
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SQ    = 3'd2;
    localparam logic [2:0] MUL   = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;

    localparam logic [IW-1:0]     I_LAST = {IW{1'b0}};
    localparam logic [IW-1:0]     I_TOP  = IW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};

    // Reduce a double-width value modulo m; a zero modulus yields zero so the
    // divider never sees an undefined operand (LOAD filters p == 0 anyway).
    function automatic logic [DATA_W-1:0] mod_reduce(
        input logic [2*DATA_W-1:0] a,
        input logic [DATA_W-1:0]   m
    );
        logic [DATA_W-1:0] res_v;
        if (m == ZERO_W) begin
            res_v = ZERO_W;
        end else begin
            res_v = DATA_W'(a % {{DATA_W{1'b0}}, m});
        end
        return res_v;
    endfunction

    logic [2:0]        state_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              true_r;
    logic [3:0]        c2_r;
    logic [3:0]        r1_r;
    logic [3:0]        r2_r;
    logic [3:0]        c1_r;
    logic [DATA_W-1:0] p_r;
    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] base_r;
    logic [IW-1:0]     i_r;

    logic [DATA_W-1:0] sq_s;
    logic [DATA_W-1:0] mul_s;
    logic [DATA_W-1:0] base_s;
    logic [3:0]        k_s;

    // Modular datapath: full-width products reduced modulo the latched p.
    always_comb begin
        sq_s   = mod_reduce({{DATA_W{1'b0}}, acc_r} * {{DATA_W{1'b0}}, acc_r}, p_r);
        mul_s  = mod_reduce({{DATA_W{1'b0}}, acc_r} * {{DATA_W{1'b0}}, base_r}, p_r);
        base_s = mod_reduce({{(2*DATA_W-4){1'b0}}, r2_r}, p_r);
        k_s    = acc_r[3:0];
    end

    // Round sequencer: latch operands, exponentiate, then judge the key nibble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            true_r  <= 1'b0;
            c2_r    <= 4'h0;
            r1_r    <= 4'h0;
            r2_r    <= 4'h0;
            c1_r    <= 4'h0;
            p_r     <= ZERO_W;
            x_r     <= ZERO_W;
            acc_r   <= ZERO_W;
            base_r  <= ZERO_W;
            i_r     <= I_LAST;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        r1_r    <= r1;
                        r2_r    <= r2;
                        c1_r    <= c1;
                        p_r     <= p;
                        x_r     <= x;
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (p_r == ZERO_W) begin
                        err_r   <= 1'b1;
                        c2_r    <= 4'h0;
                        true_r  <= 1'b0;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        acc_r   <= ONE_W;
                        base_r  <= base_s;
                        i_r     <= I_TOP;
                        state_r <= SQ;
                    end
                end
                SQ: begin
                    acc_r <= sq_s;
                    // A set bit keeps the index for the following MUL step.
                    if (x_r[i_r]) begin
                        state_r <= MUL;
                    end else if (i_r == I_LAST) begin
                        state_r <= CHECK;
                    end else begin
                        i_r     <= i_r - 1'b1;
                    end
                end
                MUL: begin
                    acc_r <= mul_s;
                    if (i_r == I_LAST) begin
                        state_r <= CHECK;
                    end else begin
                        i_r     <= i_r - 1'b1;
                        state_r <= SQ;
                    end
                end
                CHECK: begin
                    // Replay: c1 decrypts under k back to the reference r2.
                    if ((k_s ^ c1_r) == r2_r) begin
                        c2_r   <= 4'h0;
                        true_r <= 1'b0;
                    end else begin
                        c2_r   <= k_s ^ r1_r;
                        true_r <= 1'b1;
                    end
                    err_r   <= 1'b0;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;
    assign true = true_r;
    assign c2   = c2_r;

endmodule

// File: tb/tb_dh_encrypt_seq.sv
// tb_dh_encrypt_seq
//   Directed stimulus with hand-computed results. Each accepted round pushes
//   its expected outputs and latency into a queue; a monitor pops and compares
//   whenever done is seen, independent of the stimulus thread.
module tb_dh_encrypt_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  c1;
    logic [31:0] p;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic        err;
    logic        true;
    logic [3:0]  c2;

    typedef struct {
        string       name;
        logic [3:0]  c2;
        logic        tr;
        logic        err;
        int          acc_edge;
        int          n;
    } exp_t;

    exp_t sb[$];

    int checks;
    int passes;
    int cyc;
    int dones_seen;
    int dones_expected;

    dh_encrypt_seq #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .r1    (r1),
        .r2    (r2),
        .c1    (c1),
        .p     (p),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .true  (true),
        .c2    (c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            dones_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_c2"},      {28'd0, c2},   {28'd0, e.c2});
                check({e.name, "_true"},    {31'd0, true}, {31'd0, e.tr});
                check({e.name, "_err"},     {31'd0, err},  {31'd0, e.err});
                check({e.name, "_busy"},    {31'd0, busy}, 32'd0);
                check({e.name, "_latency"}, cyc - e.acc_edge, e.n);
            end
        end
    end

    // Issue one round. now=1 drives start in the current negedge (the done
    // cycle of the previous round); poke pulses start at relative edges 5 and
    // 20; abort_at>0 pulls rst low at that relative edge instead of finishing.
    task automatic run_round(
        input string      name,
        input logic [3:0] v_r1, input logic [3:0] v_r2, input logic [3:0] v_c1,
        input logic [31:0] v_p, input logic [31:0] v_x,
        input logic [3:0] e_c2, input logic e_tr, input logic e_err, input int e_n,
        input bit now, input bit poke, input int abort_at
    );
        exp_t e;
        bit   seen;
        if (!now) @(negedge clk);
        r1 = v_r1; r2 = v_r2; c1 = v_c1; p = v_p; x = v_x;
        start = 1'b1;
        if (abort_at == 0) begin
            e.name = name; e.c2 = e_c2; e.tr = e_tr; e.err = e_err;
            e.acc_edge = cyc + 1; e.n = e_n;
            sb.push_back(e);
            dones_expected++;
        end
        @(negedge clk);
        start = 1'b0;
        r1 = 4'($urandom); r2 = 4'($urandom); c1 = 4'($urandom);
        p = $urandom; x = $urandom;
        seen = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            start = (poke && (k == 5 || k == 20)) ? 1'b1 : 1'b0;
            if (abort_at > 0 && k == abort_at) rst = 1'b0;
            @(negedge clk);
            if (abort_at > 0 && k == abort_at) begin
                start = 1'b0;
                check({name, "_rst_busy"}, {31'd0, busy}, 32'd0);
                check({name, "_rst_done"}, {31'd0, done}, 32'd0);
                check({name, "_rst_err"},  {31'd0, err},  32'd0);
                check({name, "_rst_true"}, {31'd0, true}, 32'd0);
                check({name, "_rst_c2"},   {28'd0, c2},   32'd0);
                rst = 1'b1;
                seen = 1'b1;
                break;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        checks = 0; passes = 0; cyc = 0; dones_seen = 0; dones_expected = 0;
        rst = 1'b0; start = 1'b0;
        r1 = 4'h0; r2 = 4'h0; c1 = 4'h0; p = 32'd0; x = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err",  {31'd0, err},  32'd0);
        check("reset_true", {31'd0, true}, 32'd0);
        check("reset_c2",   {28'd0, c2},   32'd0);
        rst = 1'b1;

        // 3^5 mod 7 = 5; 5^6 = 3 = r2 -> replay.
        run_round("replay", 4'hA, 4'd3, 4'd6, 32'd7, 32'd5, 4'h0, 1'b0, 1'b0, 36, 1'b0, 1'b0, 0);
        // 2^10 mod 13 = 10; c2 = 10^5 = 0xF.
        run_round("encrypt", 4'd5, 4'd2, 4'd0, 32'd13, 32'd10, 4'hF, 1'b1, 1'b0, 36, 1'b0, 1'b0, 0);
        // x = 0 -> k = 1; c2 = 1^3 = 2.
        run_round("x_zero", 4'd3, 4'd9, 4'd1, 32'd11, 32'd0, 4'h2, 1'b1, 1'b0, 34, 1'b0, 1'b0, 0);
        // p = 0 -> abort at edge 1.
        run_round("p_zero", 4'd3, 4'd9, 4'd1, 32'd0, 32'd5, 4'h0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("err_held", {31'd0, err}, 32'd1);
        // Valid round after p = 0 clears err.
        run_round("err_clear", 4'hA, 4'd3, 4'd6, 32'd7, 32'd5, 4'h0, 1'b0, 1'b0, 36, 1'b0, 1'b0, 0);
        // p = 1 -> acc = 0; 0^3 != 5 -> c2 = 0^6 = 6.
        run_round("p_one", 4'd6, 4'd5, 4'd3, 32'd1, 32'd7, 4'h6, 1'b1, 1'b0, 37, 1'b0, 1'b0, 0);
        // r2 = 15 >= p = 7 -> base 1, acc 1; c2 = 1^0 = 1.
        run_round("r2_reduce", 4'd0, 4'd15, 4'd0, 32'd7, 32'd1, 4'h1, 1'b1, 1'b0, 35, 1'b0, 1'b0, 0);
        // 3^3 mod 5 = 2; 2^2 = 0 != 3 -> c2 = 2^1 = 3; start pokes ignored.
        run_round("ignore_start", 4'd1, 4'd3, 4'd2, 32'd5, 32'd3, 4'h3, 1'b1, 1'b0, 36, 1'b0, 1'b1, 0);
        // Start in the done cycle of the previous round.
        run_round("back2back", 4'd5, 4'd2, 4'd0, 32'd13, 32'd10, 4'hF, 1'b1, 1'b0, 36, 1'b1, 1'b0, 0);
        // Reset at edge 10 of a round: everything clears, no done.
        run_round("abort", 4'd5, 4'd2, 4'd0, 32'd13, 32'd10, 4'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 10);
        repeat (40) @(negedge clk);
        // Restarted round after the abort.
        run_round("restart", 4'd3, 4'd9, 4'd1, 32'd11, 32'd0, 4'h2, 1'b1, 1'b0, 34, 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);

        check("done_count", dones_seen, dones_expected);
        check("queue_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
